// File: rtl/sgd_mem_rd_arbiter.sv
// Round-robin sharing of one memory read command channel and its in-order read-data return
// between requester A (dataset fetch) and B (model fetch). Optional counters: SGD_RD_ARB_STATS_EN.
module sgd_mem_rd_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int LEN_W          = 32,
  parameter int DATA_W         = 512,
  parameter int TAG_DEPTH_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_a_cmd_valid,
  output logic                    s_a_cmd_ready,
  input  logic [ADDR_W-1:0]       s_a_cmd_address,
  input  logic [LEN_W-1:0]        s_a_cmd_length,
  input  logic                    s_b_cmd_valid,
  output logic                    s_b_cmd_ready,
  input  logic [ADDR_W-1:0]       s_b_cmd_address,
  input  logic [LEN_W-1:0]        s_b_cmd_length,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic [ADDR_W-1:0]       m_cmd_address,
  output logic [LEN_W-1:0]        m_cmd_length,
  output logic [7:0]              m_cmd_tag,
  input  logic                    s_rd_valid,
  output logic                    s_rd_ready,
  input  logic [DATA_W-1:0]       s_rd_data,
  input  logic [DATA_W/8-1:0]     s_rd_keep,
  input  logic                    s_rd_last,
  output logic                    m_a_rd_valid,
  input  logic                    m_a_rd_ready,
  output logic [DATA_W-1:0]       m_a_rd_data,
  output logic [DATA_W/8-1:0]     m_a_rd_keep,
  output logic                    m_a_rd_last,
  output logic                    m_b_rd_valid,
  input  logic                    m_b_rd_ready,
  output logic [DATA_W-1:0]       m_b_rd_data,
  output logic [DATA_W/8-1:0]     m_b_rd_keep,
  output logic                    m_b_rd_last,
  output logic [TAG_DEPTH_BITS:0] outstanding,
  output logic [31:0]             stat_a_cmds,
  output logic [31:0]             stat_b_cmds,
  output logic [31:0]             stat_a_beats,
  output logic [31:0]             stat_b_beats
);

  localparam logic [7:0] TAG_A = 8'h0a;
  localparam logic [7:0] TAG_B = 8'h0b;
  localparam int DEPTH = 1 << TAG_DEPTH_BITS;
  localparam logic [TAG_DEPTH_BITS:0] FULL_COUNT = {1'b1, {TAG_DEPTH_BITS{1'b0}}};

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                    state;
  logic                      last_grant_b;
  logic                      cmd_is_b;
  logic                      fifo_mem [DEPTH];
  logic [TAG_DEPTH_BITS-1:0] wr_ptr;
  logic [TAG_DEPTH_BITS-1:0] rd_ptr;
  logic [TAG_DEPTH_BITS:0]   count;

  logic fifo_full, fifo_nonempty, head_b;
  logic grant_b, can_accept, a_hs, b_hs;
  logic push, pop, route_a, route_b;
  logic [LEN_W-1:0] sel_len;

  // A tie goes to whoever did not win last; a lone requester always wins.
  assign grant_b    = s_b_cmd_valid && (!s_a_cmd_valid || !last_grant_b);
  assign fifo_full  = (count == FULL_COUNT);
  assign can_accept = rst_n && (state == IDLE) && !fifo_full;

  assign s_a_cmd_ready = can_accept && s_a_cmd_valid && !grant_b;
  assign s_b_cmd_ready = can_accept && grant_b;
  assign a_hs          = s_a_cmd_valid && s_a_cmd_ready;
  assign b_hs          = s_b_cmd_valid && s_b_cmd_ready;
  assign sel_len       = b_hs ? s_b_cmd_length : s_a_cmd_length;

  assign m_cmd_valid = (state == ISSUE);
  assign push        = (state == ISSUE) && m_cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant_b  <= 1'b1;
      cmd_is_b      <= 1'b0;
      m_cmd_address <= '0;
      m_cmd_length  <= '0;
      m_cmd_tag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_hs || b_hs) begin
            m_cmd_address <= b_hs ? s_b_cmd_address : s_a_cmd_address;
            m_cmd_length  <= sel_len;
            m_cmd_tag     <= b_hs ? TAG_B : TAG_A;
            cmd_is_b      <= b_hs;
            last_grant_b  <= b_hs;
            // Zero-length commands are swallowed: nothing issued, no response expected.
            if (sel_len != '0) state <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_cmd_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-order tag FIFO: one bit per outstanding response, 1 means B.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_is_b;
  end

  assign outstanding   = count;
  assign fifo_nonempty = (count != '0);
  assign head_b        = fifo_mem[rd_ptr];

  // Head is read from registered state, so the beat after a last goes to the next owner.
  assign route_a    = rst_n && fifo_nonempty && !head_b;
  assign route_b    = rst_n && fifo_nonempty && head_b;
  assign s_rd_ready = (route_a && m_a_rd_ready) || (route_b && m_b_rd_ready);
  assign pop        = s_rd_valid && s_rd_ready && s_rd_last;

  assign m_a_rd_valid = route_a && s_rd_valid;
  assign m_a_rd_data  = route_a ? s_rd_data : '0;
  assign m_a_rd_keep  = route_a ? s_rd_keep : '0;
  assign m_a_rd_last  = route_a && s_rd_last;
  assign m_b_rd_valid = route_b && s_rd_valid;
  assign m_b_rd_data  = route_b ? s_rd_data : '0;
  assign m_b_rd_keep  = route_b ? s_rd_keep : '0;
  assign m_b_rd_last  = route_b && s_rd_last;

`ifdef SGD_RD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_a_cmds  <= '0;
      stat_b_cmds  <= '0;
      stat_a_beats <= '0;
      stat_b_beats <= '0;
    end else begin
      if (push && !cmd_is_b)              stat_a_cmds  <= stat_a_cmds + 32'd1;
      if (push && cmd_is_b)               stat_b_cmds  <= stat_b_cmds + 32'd1;
      if (m_a_rd_valid && m_a_rd_ready)   stat_a_beats <= stat_a_beats + 32'd1;
      if (m_b_rd_valid && m_b_rd_ready)   stat_b_beats <= stat_b_beats + 32'd1;
    end
  end
`else
  assign stat_a_cmds  = 32'd0;
  assign stat_b_cmds  = 32'd0;
  assign stat_a_beats = 32'd0;
  assign stat_b_beats = 32'd0;
`endif

endmodule

// File: tb/tb_sgd_mem_rd_arbiter.sv
// Scoreboard bench for sgd_mem_rd_arbiter: command grant/tagging, tag FIFO limits and
// in-order read-data steering. Stat values are checked according to SGD_RD_ARB_STATS_EN.
module tb_sgd_mem_rd_arbiter;

  localparam int ADDR_W = 64;
  localparam int LEN_W  = 32;
  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int TDB    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              s_a_cmd_valid, s_a_cmd_ready, s_b_cmd_valid, s_b_cmd_ready;
  logic [ADDR_W-1:0] s_a_cmd_address, s_b_cmd_address, m_cmd_address;
  logic [LEN_W-1:0]  s_a_cmd_length, s_b_cmd_length, m_cmd_length;
  logic              m_cmd_valid, m_cmd_ready;
  logic [7:0]        m_cmd_tag;
  logic              s_rd_valid, s_rd_ready, s_rd_last;
  logic [DATA_W-1:0] s_rd_data, m_a_rd_data, m_b_rd_data;
  logic [KEEP_W-1:0] s_rd_keep, m_a_rd_keep, m_b_rd_keep;
  logic              m_a_rd_valid, m_a_rd_ready, m_a_rd_last;
  logic              m_b_rd_valid, m_b_rd_ready, m_b_rd_last;
  logic [TDB:0]      outstanding;
  logic [31:0]       stat_a_cmds, stat_b_cmds, stat_a_beats, stat_b_beats;

  sgd_mem_rd_arbiter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .TAG_DEPTH_BITS(TDB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_a_cmd_valid(s_a_cmd_valid), .s_a_cmd_ready(s_a_cmd_ready),
    .s_a_cmd_address(s_a_cmd_address), .s_a_cmd_length(s_a_cmd_length),
    .s_b_cmd_valid(s_b_cmd_valid), .s_b_cmd_ready(s_b_cmd_ready),
    .s_b_cmd_address(s_b_cmd_address), .s_b_cmd_length(s_b_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length), .m_cmd_tag(m_cmd_tag),
    .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_data(s_rd_data),
    .s_rd_keep(s_rd_keep), .s_rd_last(s_rd_last),
    .m_a_rd_valid(m_a_rd_valid), .m_a_rd_ready(m_a_rd_ready), .m_a_rd_data(m_a_rd_data),
    .m_a_rd_keep(m_a_rd_keep), .m_a_rd_last(m_a_rd_last),
    .m_b_rd_valid(m_b_rd_valid), .m_b_rd_ready(m_b_rd_ready), .m_b_rd_data(m_b_rd_data),
    .m_b_rd_keep(m_b_rd_keep), .m_b_rd_last(m_b_rd_last),
    .outstanding(outstanding),
    .stat_a_cmds(stat_a_cmds), .stat_b_cmds(stat_b_cmds),
    .stat_a_beats(stat_a_beats), .stat_b_beats(stat_b_beats)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [7:0]        tag;
  } cmd_t;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } beat_t;

  int n_chk  = 0;
  int n_fail = 0;
  int beat_seq = 0;

  cmd_t  cmd_exp[$], cmd_obs[$];
  beat_t a_exp[$], a_obs[$], b_exp[$], b_obs[$];
  bit    tag_model[$];

  // Observed traffic is captured on the falling edge, where every input is stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_cmd_valid && m_cmd_ready) cmd_obs.push_back({m_cmd_address, m_cmd_length, m_cmd_tag});
      if (m_a_rd_valid && m_a_rd_ready) a_obs.push_back({m_a_rd_last, m_a_rd_keep, m_a_rd_data});
      if (m_b_rd_valid && m_b_rd_ready) b_obs.push_back({m_b_rd_last, m_b_rd_keep, m_b_rd_data});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_a_cmd_valid = 1'b0; s_a_cmd_address = '0; s_a_cmd_length = '0;
    s_b_cmd_valid = 1'b0; s_b_cmd_address = '0; s_b_cmd_length = '0;
    m_cmd_ready = 1'b0; s_rd_valid = 1'b0; s_rd_data = '0; s_rd_keep = '0; s_rd_last = 1'b0;
    m_a_rd_ready = 1'b0; m_b_rd_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) cyc();
    rst_n = 1'b1;
    cmd_exp.delete(); cmd_obs.delete(); tag_model.delete();
    a_exp.delete(); a_obs.delete(); b_exp.delete(); b_obs.delete();
    cyc();
  endtask

  // Presents one command until accepted; records what the memory side should later see.
  task automatic issue(input bit is_b, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    bit done = 1'b0;
    if (is_b) begin s_b_cmd_valid = 1'b1; s_b_cmd_address = addr; s_b_cmd_length = len; end
    else      begin s_a_cmd_valid = 1'b1; s_a_cmd_address = addr; s_a_cmd_length = len; end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (is_b ? s_b_cmd_ready : s_a_cmd_ready) begin
        done = 1'b1;
        if (len != '0) begin
          cmd_exp.push_back({addr, len, is_b ? 8'h0b : 8'h0a});
          tag_model.push_back(is_b);
        end
      end
      cyc();
    end
    s_a_cmd_valid = 1'b0;
    s_b_cmd_valid = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: got no handshake want handshake (is_b=%0b)", is_b);
    end
  endtask

  // Presents one read beat until taken; the destination comes from the bench's own tag order.
  task automatic send_beat(input logic last);
    bit done = 1'b0;
    beat_t bt;
    bt.data = {16{32'hD000_0000 + 32'(beat_seq)}};
    bt.keep = {8{8'(beat_seq + 1)}};
    bt.last = last;
    beat_seq++;
    s_rd_valid = 1'b1; s_rd_data = bt.data; s_rd_keep = bt.keep; s_rd_last = last;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (s_rd_ready) begin
        done = 1'b1;
        if (tag_model.size() != 0) begin
          if (tag_model[0]) b_exp.push_back(bt); else a_exp.push_back(bt);
          if (last) void'(tag_model.pop_front());
        end
      end
      cyc();
    end
    s_rd_valid = 1'b0; s_rd_last = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL beat_timeout: got s_rd_ready=0 want 1");
    end
  endtask

  task automatic drain();
    m_a_rd_ready = 1'b1;
    m_b_rd_ready = 1'b1;
    for (int i = 0; i < 40 && tag_model.size() != 0; i++) send_beat(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_a_cmd_valid = 1'b1; s_a_cmd_address = 64'h55; s_a_cmd_length = 32'd64;
    s_b_cmd_valid = 1'b1; s_b_cmd_address = 64'h66; s_b_cmd_length = 32'd64;
    m_cmd_ready = 1'b1; s_rd_valid = 1'b1; s_rd_last = 1'b1; s_rd_data = '1; s_rd_keep = '1;
    m_a_rd_ready = 1'b1; m_b_rd_ready = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    n_chk++;
    if ({m_cmd_valid, s_a_cmd_ready, s_b_cmd_ready, s_rd_ready, m_a_rd_valid, m_b_rd_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_handshakes: got %b want 000000",
               {m_cmd_valid, s_a_cmd_ready, s_b_cmd_ready, s_rd_ready, m_a_rd_valid, m_b_rd_valid});
    end
    n_chk++;
    if (outstanding !== '0) begin
      n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
    end
    n_chk++;
    if ({m_cmd_address, m_cmd_length, m_cmd_tag} !== '0) begin
      n_fail++; $display("FAIL reset_cmd_fields: got %h/%h/%h want 0", m_cmd_address, m_cmd_length, m_cmd_tag);
    end
    n_chk++;
    if ({stat_a_cmds, stat_b_cmds, stat_a_beats, stat_b_beats} !== '0) begin
      n_fail++; $display("FAIL reset_stats: got %0d %0d %0d %0d want 0", stat_a_cmds, stat_b_cmds, stat_a_beats, stat_b_beats);
    end
    cyc();
    apply_reset();
  endtask

  task automatic test_single_a();
    m_cmd_ready = 1'b1; m_a_rd_ready = 1'b1; m_b_rd_ready = 1'b1;
    s_a_cmd_valid = 1'b1; s_a_cmd_address = 64'h1000; s_a_cmd_length = 32'd256;
    @(negedge clk);
    n_chk++;
    if ({s_a_cmd_ready, s_b_cmd_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_a_ready: got %b want 10", {s_a_cmd_ready, s_b_cmd_ready});
    end
    cmd_exp.push_back({64'h1000, 32'd256, 8'h0a});
    tag_model.push_back(1'b0);
    cyc();
    s_a_cmd_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m_cmd_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_a_latency: got m_cmd_valid=%b want 1", m_cmd_valid);
    end
    n_chk++;
    if ({m_cmd_address, m_cmd_length, m_cmd_tag} !== {64'h1000, 32'd256, 8'h0a}) begin
      n_fail++; $display("FAIL single_a_fields: got %h/%0d/%h want 1000/256/0a", m_cmd_address, m_cmd_length, m_cmd_tag);
    end
    cyc();
    @(negedge clk);
    n_chk++;
    if ({m_cmd_valid, outstanding} !== {1'b0, 5'd1}) begin
      n_fail++; $display("FAIL single_a_outstanding1: got valid=%b out=%0d want valid=0 out=1", m_cmd_valid, outstanding);
    end
    cyc();
    for (int k = 0; k < 4; k++) send_beat(k == 3);
    @(negedge clk);
    n_chk++;
    if (outstanding !== 5'd0) begin
      n_fail++; $display("FAIL single_a_outstanding0: got %0d want 0", outstanding);
    end
    n_chk++;
    if (a_obs.size() != 4 || b_obs.size() != 0) begin
      n_fail++; $display("FAIL single_a_beat_count: got a=%0d b=%0d want a=4 b=0", a_obs.size(), b_obs.size());
    end
    while (a_obs.size() != 0 && a_exp.size() != 0) begin
      beat_t ob = a_obs.pop_front();
      beat_t ex = a_exp.pop_front();
      n_chk++;
      if (ob !== ex) begin
        n_fail++; $display("FAIL single_a_beat: got last=%b data=%h want last=%b data=%h", ob.last, ob.data[63:0], ex.last, ex.data[63:0]);
      end
    end
    n_chk++;
    if (cmd_obs.size() != 1 || cmd_obs[0] !== cmd_exp[0]) begin
      n_fail++; $display("FAIL single_a_cmd_scoreboard: got %0d cmds want 1 matching", cmd_obs.size());
    end
`ifdef SGD_RD_ARB_STATS_EN
    n_chk++;
    if ({stat_a_cmds, stat_a_beats, stat_b_cmds, stat_b_beats} !== {32'd1, 32'd4, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL single_a_stats: got %0d %0d %0d %0d want 1 4 0 0", stat_a_cmds, stat_a_beats, stat_b_cmds, stat_b_beats);
    end
`else
    n_chk++;
    if ({stat_a_cmds, stat_a_beats, stat_b_cmds, stat_b_beats} !== '0) begin
      n_fail++; $display("FAIL single_a_stats: got %0d %0d %0d %0d want 0 0 0 0", stat_a_cmds, stat_a_beats, stat_b_cmds, stat_b_beats);
    end
`endif
    cyc();
    cmd_exp.delete(); cmd_obs.delete(); a_exp.delete(); b_exp.delete();
  endtask

  task automatic test_alternate();
    logic [7:0] want_tags [4];
    int got = 0;
    int na = 0;
    int nb = 0;
    want_tags = '{8'h0a, 8'h0b, 8'h0a, 8'h0b};
    apply_reset();
    m_cmd_ready = 1'b1;
    s_a_cmd_valid = 1'b1; s_a_cmd_length = 32'd64;
    s_b_cmd_valid = 1'b1; s_b_cmd_length = 32'd128;
    for (int i = 0; i < 40 && got < 4; i++) begin
      s_a_cmd_address = 64'hA000 + 64'(na);
      s_b_cmd_address = 64'hB000 + 64'(nb);
      @(negedge clk);
      n_chk++;
      if (s_a_cmd_ready && s_b_cmd_ready) begin
        n_fail++; $display("FAIL alt_both_ready: got 11 want at most one");
      end
      if (s_a_cmd_ready) begin
        cmd_exp.push_back({s_a_cmd_address, 32'd64, 8'h0a}); tag_model.push_back(1'b0); na++; got++;
      end else if (s_b_cmd_ready) begin
        cmd_exp.push_back({s_b_cmd_address, 32'd128, 8'h0b}); tag_model.push_back(1'b1); nb++; got++;
      end
      cyc();
    end
    s_a_cmd_valid = 1'b0; s_b_cmd_valid = 1'b0;
    repeat (2) cyc();
    n_chk++;
    if (cmd_obs.size() != 4) begin
      n_fail++; $display("FAIL alt_cmd_count: got %0d want 4", cmd_obs.size());
    end
    for (int i = 0; i < 4 && i < cmd_obs.size(); i++) begin
      n_chk++;
      if (cmd_obs[i].tag !== want_tags[i]) begin
        n_fail++; $display("FAIL alt_tag_order[%0d]: got %h want %h", i, cmd_obs[i].tag, want_tags[i]);
      end
      n_chk++;
      if (i < cmd_exp.size() && cmd_obs[i] !== cmd_exp[i]) begin
        n_fail++; $display("FAIL alt_cmd[%0d]: got %h/%h want %h/%h", i, cmd_obs[i].addr, cmd_obs[i].len, cmd_exp[i].addr, cmd_exp[i].len);
      end
    end
    drain();
    @(negedge clk);
    n_chk++;
    if (a_obs.size() != 2 || b_obs.size() != 2 || a_obs !== a_exp || b_obs !== b_exp) begin
      n_fail++; $display("FAIL alt_routing: got a=%0d b=%0d beats want a=2 b=2 matching", a_obs.size(), b_obs.size());
    end
    cyc();
    cmd_exp.delete(); cmd_obs.delete(); a_exp.delete(); a_obs.delete(); b_exp.delete(); b_obs.delete();
  endtask

  task automatic test_full();
    int n = 0;
    bit accepted = 1'b0;
    m_cmd_ready = 1'b1; m_a_rd_ready = 1'b0; m_b_rd_ready = 1'b0;
    s_b_cmd_valid = 1'b1; s_b_cmd_length = 32'd64;
    for (int i = 0; i < 100 && n < 16; i++) begin
      s_b_cmd_address = 64'hC000 + 64'(n);
      @(negedge clk);
      if (s_b_cmd_ready) begin
        cmd_exp.push_back({s_b_cmd_address, 32'd64, 8'h0b}); tag_model.push_back(1'b1); n++;
      end
      cyc();
    end
    s_b_cmd_address = 64'hC000 + 64'(n);
    repeat (4) begin
      @(negedge clk);
      n_chk++;
      if (s_b_cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL full_ready: got s_b_cmd_ready=%b want 0", s_b_cmd_ready);
      end
      cyc();
    end
    @(negedge clk);
    n_chk++;
    if (outstanding !== 5'd16) begin
      n_fail++; $display("FAIL full_outstanding: got %0d want 16", outstanding);
    end
    cyc();
    m_b_rd_ready = 1'b1;
    send_beat(1'b1);
    for (int i = 0; i < 3 && !accepted; i++) begin
      @(negedge clk);
      if (s_b_cmd_ready) begin
        accepted = 1'b1;
        cmd_exp.push_back({s_b_cmd_address, 32'd64, 8'h0b}); tag_model.push_back(1'b1);
      end
      cyc();
    end
    s_b_cmd_valid = 1'b0;
    n_chk++;
    if (!accepted) begin
      n_fail++; $display("FAIL full_17th_accept: got not accepted want accepted");
    end
    repeat (2) cyc();
    drain();
    @(negedge clk);
    n_chk++;
    if (outstanding !== 5'd0 || b_obs.size() != 17 || b_obs !== b_exp || a_obs.size() != 0) begin
      n_fail++; $display("FAIL full_drain: got out=%0d b=%0d a=%0d want out=0 b=17 a=0", outstanding, b_obs.size(), a_obs.size());
    end
    n_chk++;
    if (cmd_obs.size() != 17 || cmd_obs !== cmd_exp) begin
      n_fail++; $display("FAIL full_cmds: got %0d cmds want 17 matching", cmd_obs.size());
    end
    cyc();
    cmd_exp.delete(); cmd_obs.delete(); a_exp.delete(); a_obs.delete(); b_exp.delete(); b_obs.delete();
  endtask

  task automatic test_len0();
    int cmds_before = cmd_obs.size();
    m_cmd_ready = 1'b1;
    s_a_cmd_valid = 1'b1; s_a_cmd_address = 64'hD000; s_a_cmd_length = 32'd0;
    @(negedge clk);
    n_chk++;
    if (s_a_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL len0_consumed: got s_a_cmd_ready=%b want 1", s_a_cmd_ready);
    end
    cyc();
    s_a_cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (m_cmd_valid !== 1'b0 || outstanding !== 5'(tag_model.size())) begin
        n_fail++; $display("FAIL len0_no_issue: got valid=%b out=%0d want valid=0 out=%0d", m_cmd_valid, outstanding, tag_model.size());
      end
      cyc();
    end
    n_chk++;
    if (cmd_obs.size() != cmds_before) begin
      n_fail++; $display("FAIL len0_cmd_count: got %0d want %0d", cmd_obs.size(), cmds_before);
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int a_last_cyc = -1;
    int b_cyc = -10;
    logic [DATA_W-1:0] bd [3];
    logic              bl [3];
    bd = '{{16{32'hAAAA_0001}}, {16{32'hAAAA_0002}}, {16{32'hBBBB_0001}}};
    bl = '{1'b0, 1'b1, 1'b1};
    m_cmd_ready = 1'b1; m_a_rd_ready = 1'b0; m_b_rd_ready = 1'b1;
    issue(1'b0, 64'hE000, 32'd128);
    cyc();
    issue(1'b1, 64'hF000, 32'd64);
    cyc();
    @(negedge clk);
    n_chk++;
    if (outstanding !== 5'd2) begin
      n_fail++; $display("FAIL b2b_outstanding: got %0d want 2", outstanding);
    end
    cyc();
    s_rd_valid = 1'b1;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      m_a_rd_ready = (c >= 3);
      s_rd_data = bd[idx]; s_rd_keep = '1; s_rd_last = bl[idx];
      @(negedge clk);
      if (c < 3) begin
        n_chk++;
        if ({s_rd_ready, m_a_rd_valid, m_b_rd_valid} !== 3'b010) begin
          n_fail++; $display("FAIL b2b_stall: got rdy/a/b=%b want 010", {s_rd_ready, m_a_rd_valid, m_b_rd_valid});
        end
      end
      if (s_rd_ready) begin
        if (tag_model.size() != 0) begin
          if (tag_model[0]) b_exp.push_back({bl[idx], {KEEP_W{1'b1}}, bd[idx]});
          else              a_exp.push_back({bl[idx], {KEEP_W{1'b1}}, bd[idx]});
          if (bl[idx]) void'(tag_model.pop_front());
        end
        if (idx == 1) a_last_cyc = c;
        if (idx == 2) b_cyc = c;
        idx++;
      end
      cyc();
    end
    s_rd_valid = 1'b0; s_rd_last = 1'b0;
    n_chk++;
    if (b_cyc != a_last_cyc + 1) begin
      n_fail++; $display("FAIL b2b_no_bubble: got B beat at cycle %0d want %0d", b_cyc, a_last_cyc + 1);
    end
    @(negedge clk);
    n_chk++;
    if (outstanding !== 5'd0 || a_obs.size() != 2 || b_obs.size() != 1 || a_obs !== a_exp || b_obs !== b_exp) begin
      n_fail++; $display("FAIL b2b_scoreboard: got out=%0d a=%0d b=%0d want out=0 a=2 b=1 matching", outstanding, a_obs.size(), b_obs.size());
    end
    cyc();
    cmd_exp.delete(); cmd_obs.delete(); a_exp.delete(); a_obs.delete(); b_exp.delete(); b_obs.delete();
  endtask

  task automatic test_reset_mid();
    m_cmd_ready = 1'b1; m_a_rd_ready = 1'b1; m_b_rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 64'h2000 + 64'(i * 64), 32'd128);
      cyc();
    end
    @(negedge clk);
    n_chk++;
    if (outstanding !== 5'd3) begin
      n_fail++; $display("FAIL rstmid_outstanding3: got %0d want 3", outstanding);
    end
    cyc();
    s_rd_valid = 1'b1; s_rd_data = {16{32'h1234_5678}}; s_rd_keep = '1; s_rd_last = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    n_chk++;
    if ({m_cmd_valid, s_a_cmd_ready, s_b_cmd_ready, s_rd_ready, m_a_rd_valid, m_b_rd_valid} !== 6'b0 || outstanding !== 5'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b out=%0d want 000000 out=0",
               {m_cmd_valid, s_a_cmd_ready, s_b_cmd_ready, s_rd_ready, m_a_rd_valid, m_b_rd_valid}, outstanding);
    end
    n_chk++;
    if ({stat_a_cmds, stat_b_cmds, stat_a_beats, stat_b_beats} !== '0) begin
      n_fail++; $display("FAIL rstmid_stats: got %0d %0d %0d %0d want 0", stat_a_cmds, stat_b_cmds, stat_a_beats, stat_b_beats);
    end
    cyc();
    rst_n = 1'b1;
    tag_model.delete();
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if ({s_rd_ready, m_a_rd_valid, m_b_rd_valid} !== 3'b000 || outstanding !== 5'd0) begin
        n_fail++; $display("FAIL rstmid_held_off: got rdy/a/b=%b out=%0d want 000 out=0", {s_rd_ready, m_a_rd_valid, m_b_rd_valid}, outstanding);
      end
      cyc();
    end
    s_rd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_a();
    test_alternate();
    test_full();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sgd_mem_rd_arbiter.md
Name: sgd_mem_rd_arbiter

Overview:
- Shares one memory-read command channel and its returning 512-bit read-data stream between two requesters.
  - A: training-dataset fetch.
  - B: model fetch.
- Round-robin arbitration on commands.
- Each forwarded command is tagged and its tag is queued in order. Returned data is steered to the requester at the queue head until a beat with last=1 closes that response.
- Sits between the SGD engine fetch logic and the memory/DMA read port.

Parameters:
- ADDR_W, 64, command address width
- LEN_W, 32, command length width (bytes)
- DATA_W, 512, read-data width (`NUM_BITS_PER_CL)
- TAG_DEPTH_BITS, 4, log2 depth of in-order tag FIFO, which equals max outstanding responses (16)

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- s_a_cmd_valid/ready  in/out  1/1  requester A command handshake
- s_a_cmd_address  in  ADDR_W  A read address
- s_a_cmd_length  in  LEN_W  A read length in bytes
- s_b_cmd_valid/ready, s_b_cmd_address, s_b_cmd_length  in/out/in/in  1/1/ADDR_W/LEN_W  requester B, same as A
- m_cmd_valid/ready  out/in  1/1  memory command handshake
- m_cmd_address  out  ADDR_W  forwarded address
- m_cmd_length  out  LEN_W  forwarded length
- m_cmd_tag  out  8  `MEM_RD_A_TAG (8'h0a) or `MEM_RD_B_TAG (8'h0b)
- s_rd_valid/ready/data/keep/last  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  memory read-data stream
- m_a_rd_valid/ready/data/keep/last  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  data to A
- m_b_rd_valid/ready/data/keep/last  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  data to B
- outstanding  out  TAG_DEPTH_BITS+1  tag FIFO occupancy
- stat_a_cmds, stat_b_cmds, stat_a_beats, stat_b_beats  out  32 each  statistics (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge): all outputs are 0. This includes every valid, every ready, m_cmd_* fields, outstanding and stats. Tag FIFO is emptied, FSM goes to IDLE, last_grant is set to B so A wins the first tie. Reset mid-transfer discards in-flight tags; there is no recovery of partial responses.
- Command FSM states: IDLE and ISSUE.
  - IDLE: s_x_cmd_ready=1 only for the granted requester, and only when the tag FIFO is not full.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one not equal to last_grant.
  - On requester handshake:
    - Register address, length and tag into m_cmd_*.
    - Update last_grant.
    - If length==0: stay in IDLE, push no tag, issue nothing (the command is consumed silently).
    - Otherwise: go to ISSUE.
  - ISSUE: m_cmd_valid=1 and m_cmd_* are held stable. Both s_x_cmd_ready=0. On m_cmd_valid&&m_cmd_ready, push the tag and return to IDLE.
  - Latency: requester handshake to m_cmd_valid is 1 cycle. Maximum command throughput is one per 2 cycles.
- Tag FIFO:
  - Depth 2^TAG_DEPTH_BITS, 1 bit per entry (0=A, 1=B).
  - Full is checked in IDLE. The push in ISSUE is guaranteed room because the grant required not-full.
  - Simultaneous push and pop in one cycle leaves occupancy unchanged.
  - outstanding equals the registered occupancy.
- Data routing (combinational, zero latency):
  - FIFO empty: s_rd_ready=0, and both m_x_rd_valid=0.
  - FIFO not empty:
    - Head selects destination X.
    - m_X_rd_valid=s_rd_valid, and data/keep/last pass through.
    - s_rd_ready=m_X_rd_ready.
    - The other destination's valid is 0.
  - Pop on s_rd_valid&&s_rd_ready&&s_rd_last.
  - The next beat routes to the new head in the following cycle. Back-to-back responses must not stall, because the pop is registered and the head is read from the registered FIFO state.
  - Backpressure from destination X never affects command issue.
- Data arriving with the FIFO empty is held off (ready=0). It is never dropped.

Optional Feature:
- Macro: SGD_RD_ARB_STATS_EN.
- Defined:
  - stat_a_cmds and stat_b_cmds increment on each non-zero-length command pushed for A or B.
  - stat_a_beats and stat_b_beats increment on each delivered beat to A or B.
  - All four are 32-bit, wrap at 2^32-1 to 0, and clear on reset.
- Undefined: the four stat ports are tied to 32'd0 and no counter logic is synthesized.

Test Plan:
- Only A sends addr=0x1000, len=256 -> m_cmd valid 1 cycle later with addr 0x1000, len 256, tag 8'h0a. Four 512b beats with last on beat 4 reach A only; outstanding goes 1 then 0.
- A and B valid every cycle with m_cmd_ready=1 -> forwarded tags alternate 0a,0b,0a,0b, starting with 0a after reset.
- Issue 16 B commands with s_rd_valid=0 -> outstanding=16, s_b_cmd_ready stays 0. After one full response (last) completes, the 17th command is accepted.
- A command with len=0 -> consumed, no m_cmd_valid, outstanding unchanged.
- Responses for A (2 beats) then B (1 beat) back-to-back, with m_a_rd_ready low for 3 cycles -> s_rd_ready low for those cycles, no beat lost. The B beat is delivered in the cycle after A's last.
- Assert rst_n=0 with outstanding=3 mid-beat -> next cycle all valids 0, outstanding 0. With SGD_RD_ARB_STATS_EN defined, the stats read 0.
